// File: rtl/fifo9_tx_arbiter.sv
// fifo9_tx_arbiter: round-robin arbiter joining two 9-bit frame FIFOs onto one GMII transmit path,
// with stray-terminator flushing, a forced inter-frame gap, per-port frame counters and underrun flagging.
module fifo9_tx_arbiter #(
    parameter int IFG_CYCLES = 12
) (
    input  logic        gmii_tx_clk,
    input  logic        sys_rst_n,
    input  logic [8:0]  dout0,
    input  logic [8:0]  dout1,
    input  logic        empty0,
    input  logic        empty1,
    output logic        rd_en0,
    output logic        rd_en1,
    input  logic [1:0]  port_en,
    output logic [8:0]  dout,
    output logic        empty,
    input  logic        rd_en,
    output logic [1:0]  grant,
    output logic [15:0] frame_cnt0,
    output logic [15:0] frame_cnt1,
    output logic        underrun
);
    typedef enum logic [1:0] {IDLE, GRANT, IFG} state_t;
    state_t      state_q, state_d;
    logic [1:0]  grant_q, grant_d;
    logic        last_q, last_d, armed_q, armed_d;
    logic [7:0]  gap_q, gap_d;
    logic [15:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
    logic [1:0]  elig;
    logic        sel, src_empty, pop, pick1, flush0;
    logic [8:0]  src_dout;

    assign elig       = port_en & {~empty1 & dout1[8], ~empty0 & dout0[8]};
    assign sel        = grant_q[1];
    assign src_dout   = sel ? dout1 : dout0;
    assign src_empty  = sel ? empty1 : empty0;
    assign pop        = rd_en & ~src_empty;
    assign pick1      = elig[1] & (~elig[0] | ~last_q);
    assign flush0     = port_en[0] & ~empty0 & ~dout0[8];
    assign grant      = grant_q;
    assign frame_cnt0 = cnt0_q;
    assign frame_cnt1 = cnt1_q;

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        last_d   = last_q;
        armed_d  = armed_q;
        gap_d    = gap_q;
        cnt0_d   = cnt0_q;
        cnt1_d   = cnt1_q;
        rd_en0   = 1'b0;
        rd_en1   = 1'b0;
        dout     = 9'h000;
        empty    = 1'b1;
        underrun = 1'b0;
        case (state_q)
            IDLE: begin
                // port 1 flush waits a cycle if port 0 is flushing, keeping pops one-hot
                rd_en0 = flush0;
                rd_en1 = port_en[1] & ~empty1 & ~dout1[8] & ~flush0;
                if (|elig) begin
                    state_d = GRANT;
                    grant_d = pick1 ? 2'b10 : 2'b01;
                    last_d  = pick1;
                    armed_d = 1'b1;
                end
            end
            GRANT: begin
                dout     = src_dout;
                empty    = src_empty;
                rd_en0   = pop & ~sel;
                rd_en1   = pop & sel;
                underrun = rd_en & src_empty & armed_q;
                armed_d  = armed_q & ~underrun;
                if (pop && !src_dout[8]) begin
                    state_d = IFG;
                    grant_d = 2'b00;
                    gap_d   = 8'(IFG_CYCLES);
                    cnt0_d  = cnt0_q + {15'd0, ~sel};
                    cnt1_d  = cnt1_q + {15'd0, sel};
                end
            end
            IFG: begin
                gap_d = gap_q - 8'd1;
                if (gap_q <= 8'd1) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge gmii_tx_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= IDLE;
            grant_q <= 2'b00;
            last_q  <= 1'b1;
            armed_q <= 1'b0;
            gap_q   <= 8'd0;
            cnt0_q  <= 16'h0000;
            cnt1_q  <= 16'h0000;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            armed_q <= armed_d;
            gap_q   <= gap_d;
            cnt0_q  <= cnt0_d;
            cnt1_q  <= cnt1_d;
        end
    end
endmodule

// File: tb/tb_fifo9_tx_arbiter.sv
// tb_fifo9_tx_arbiter: scenario tasks plus randomized traffic, checked every cycle against a
// frame-level reference model driven by bench-owned source FIFO queues.
module tb_fifo9_tx_arbiter;
    localparam int IFG = 12;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [8:0]  dout0, dout1, dout;
    logic        empty0, empty1, rd_en0, rd_en1, empty, rd_en, underrun;
    logic [1:0]  port_en, grant;
    logic [15:0] frame_cnt0, frame_cnt1;

    fifo9_tx_arbiter #(.IFG_CYCLES(IFG)) dut (
        .gmii_tx_clk(clk), .sys_rst_n(rst_n),
        .dout0(dout0), .dout1(dout1), .empty0(empty0), .empty1(empty1),
        .rd_en0(rd_en0), .rd_en1(rd_en1), .port_en(port_en),
        .dout(dout), .empty(empty), .rd_en(rd_en),
        .grant(grant), .frame_cnt0(frame_cnt0), .frame_cnt1(frame_cnt1),
        .underrun(underrun)
    );

    always #5 clk = ~clk;

    int passed = 0, total = 0, cyc = 0;
    logic [8:0] src0[$], src1[$], rx[$];
    logic hold0 = 1'b0, hold1 = 1'b0;
    logic [1:0] m_grant, g_prev;
    logic m_last, m_armed;
    int m_free;
    logic [15:0] m_cnt0, m_cnt1;
    int ev_port[$], ev_cyc[$];
    int drop_cyc, flush0_n, flush1_n, last_flush1, ur_n;

    task automatic refresh();
        empty0 = hold0 || src0.size() == 0;
        empty1 = hold1 || src1.size() == 0;
        dout0  = src0.size() != 0 ? src0[0] : 9'h000;
        dout1  = src1.size() != 0 ? src1[0] : 9'h000;
    endtask

    task automatic model_reset();
        m_grant = 2'b00; m_last = 1'b1; m_armed = 1'b0; m_free = 0;
        m_cnt0 = 16'h0; m_cnt1 = 16'h0; g_prev = 2'b00;
    endtask

    task automatic clear_logs();
        rx.delete(); ev_port.delete(); ev_cyc.delete();
        drop_cyc = 0; flush0_n = 0; flush1_n = 0; last_flush1 = 0; ur_n = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        src0.delete(); src1.delete(); hold0 = 1'b0; hold1 = 1'b0;
        refresh();
        #1;
        model_reset();
        clear_logs();
        @(posedge clk); #2;
        rst_n = 1'b1;
    endtask

    task automatic push_frame(input int port, input int n);
        logic [8:0] w;
        for (int i = 0; i < n; i++) begin
            w = (i == n - 1) ? {1'b0, 8'($urandom)} : {1'b1, 8'($urandom)};
            if (port == 0) src0.push_back(w); else src1.push_back(w);
        end
        refresh();
    endtask

    // One clock: compare DUT against the model for this cycle, advance the model, then let FIFOs pop.
    task automatic step();
        logic idle, he, f0, f1, e0, e1, pk1, xr0, xr1, xu, xe, p0, p1;
        logic [8:0] hd, xd;
        #1;
        idle = (m_grant == 2'b00) && (cyc >= m_free);
        hd   = m_grant[1] ? dout1 : dout0;
        he   = m_grant[1] ? empty1 : empty0;
        f0   = idle && port_en[0] && !empty0 && !dout0[8];
        f1   = idle && port_en[1] && !empty1 && !dout1[8] && !f0;
        xr0  = f0 || (m_grant[0] && rd_en && !empty0);
        xr1  = f1 || (m_grant[1] && rd_en && !empty1);
        xd   = (m_grant != 2'b00) ? hd : 9'h000;
        xe   = (m_grant != 2'b00) ? he : 1'b1;
        xu   = (m_grant != 2'b00) && rd_en && he && m_armed;
        total++; if (grant !== m_grant) $display("FAIL grant @%0d got %b exp %b", cyc, grant, m_grant); else passed++;
        total++; if (dout !== xd) $display("FAIL dout @%0d got %h exp %h", cyc, dout, xd); else passed++;
        total++; if (empty !== xe) $display("FAIL empty @%0d got %b exp %b", cyc, empty, xe); else passed++;
        total++; if (rd_en0 !== xr0) $display("FAIL rd_en0 @%0d got %b exp %b", cyc, rd_en0, xr0); else passed++;
        total++; if (rd_en1 !== xr1) $display("FAIL rd_en1 @%0d got %b exp %b", cyc, rd_en1, xr1); else passed++;
        total++; if (underrun !== xu) $display("FAIL underrun @%0d got %b exp %b", cyc, underrun, xu); else passed++;
        total++; if (frame_cnt0 !== m_cnt0) $display("FAIL frame_cnt0 @%0d got %0d exp %0d", cyc, frame_cnt0, m_cnt0); else passed++;
        total++; if (frame_cnt1 !== m_cnt1) $display("FAIL frame_cnt1 @%0d got %0d exp %0d", cyc, frame_cnt1, m_cnt1); else passed++;
        if (grant != 2'b00 && g_prev == 2'b00) begin ev_port.push_back(grant[1] ? 1 : 0); ev_cyc.push_back(cyc); end
        if (grant == 2'b00 && g_prev != 2'b00) drop_cyc = cyc;
        g_prev = grant;
        if (grant == 2'b00 && rd_en0) flush0_n++;
        if (grant == 2'b00 && rd_en1) begin flush1_n++; last_flush1 = cyc; end
        if (underrun) ur_n++;
        if (grant != 2'b00 && rd_en && !empty) rx.push_back(dout);
        if (m_grant != 2'b00) begin
            if (xu) m_armed = 1'b0;
            if (rd_en && !he && !hd[8]) begin
                if (m_grant[1]) m_cnt1++; else m_cnt0++;
                m_grant = 2'b00;
                m_free = cyc + IFG + 1;
            end
        end else if (idle) begin
            e0 = port_en[0] && !empty0 && dout0[8];
            e1 = port_en[1] && !empty1 && dout1[8];
            if (e0 || e1) begin
                pk1 = e1 && (!e0 || !m_last);
                m_grant = pk1 ? 2'b10 : 2'b01;
                m_last = pk1;
                m_armed = 1'b1;
            end
        end
        p0 = rd_en0; p1 = rd_en1;
        @(posedge clk); #1;
        cyc++;
        if (p0 && src0.size() != 0) void'(src0.pop_front());
        if (p1 && src1.size() != 0) void'(src1.pop_front());
        refresh();
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        model_reset();
        #2;
        total++; if (grant !== 2'b00) $display("FAIL rst_grant got %b exp 00", grant); else passed++;
        total++; if (empty !== 1'b1) $display("FAIL rst_empty got %b exp 1", empty); else passed++;
        total++; if (dout !== 9'h000) $display("FAIL rst_dout got %h exp 000", dout); else passed++;
        total++; if ({rd_en0, rd_en1} !== 2'b00) $display("FAIL rst_rd_en got %b exp 00", {rd_en0, rd_en1}); else passed++;
        total++; if (frame_cnt0 !== 16'h0 || frame_cnt1 !== 16'h0) $display("FAIL rst_cnt got %h/%h exp 0/0", frame_cnt0, frame_cnt1); else passed++;
        total++; if (underrun !== 1'b0) $display("FAIL rst_underrun got %b exp 0", underrun); else passed++;
        @(posedge clk); #2;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step();
    endtask

    task automatic test_single_frame();
        logic [8:0] exp_w [3];
        exp_w = '{9'h1FF, 9'h1AA, 9'h033};
        do_reset();
        port_en = 2'b11; rd_en = 1'b1;
        src0.push_back(9'h1FF); src0.push_back(9'h1AA); src0.push_back(9'h033);
        refresh();
        step();
        #1;
        total++; if (grant !== 2'b01) $display("FAIL single_grant got %b exp 01", grant); else passed++;
        total++; if (empty !== 1'b0 || dout !== 9'h1FF) $display("FAIL single_latency got empty=%b dout=%h exp 0/1ff", empty, dout); else passed++;
        src1.push_back(9'h055);
        refresh();
        for (int i = 0; i < 20; i++) step();
        total++; if (rx.size() != 3) $display("FAIL single_rx_len got %0d exp 3", rx.size()); else passed++;
        for (int i = 0; i < 3 && i < rx.size(); i++) begin
            total++; if (rx[i] !== exp_w[i]) $display("FAIL single_rx%0d got %h exp %h", i, rx[i], exp_w[i]); else passed++;
        end
        total++; if (frame_cnt0 !== 16'd1) $display("FAIL single_cnt0 got %0d exp 1", frame_cnt0); else passed++;
        // the stray terminator parked on port 1 can only be flushed once the gap has fully elapsed
        total++; if (flush1_n != 1 || last_flush1 - drop_cyc != IFG) $display("FAIL single_ifg_len got flushes=%0d gap=%0d exp 1/%0d", flush1_n, last_flush1 - drop_cyc, IFG); else passed++;
    endtask

    task automatic test_contention();
        int n = 0;
        do_reset();
        port_en = 2'b11; rd_en = 1'b1;
        for (int i = 0; i < 4; i++) begin push_frame(0, 4); push_frame(1, 4); end
        while ((frame_cnt0 != 16'd4 || frame_cnt1 != 16'd4) && n < 300) begin step(); n++; end
        total++; if (ev_port.size() != 8) $display("FAIL cont_grants got %0d exp 8", ev_port.size()); else passed++;
        for (int i = 0; i < ev_port.size(); i++) begin
            total++; if (ev_port[i] != i % 2) $display("FAIL cont_order%0d got %0d exp %0d", i, ev_port[i], i % 2); else passed++;
        end
        // four pop cycles, the gap, then the one IDLE arbitration cycle
        for (int i = 1; i < ev_cyc.size(); i++) begin
            total++; if (ev_cyc[i] - ev_cyc[i-1] != 4 + IFG + 1) $display("FAIL cont_spacing%0d got %0d exp %0d", i, ev_cyc[i] - ev_cyc[i-1], 4 + IFG + 1); else passed++;
        end
        total++; if (frame_cnt0 !== 16'd4 || frame_cnt1 !== 16'd4) $display("FAIL cont_cnt got %0d/%0d exp 4/4", frame_cnt0, frame_cnt1); else passed++;
    endtask

    task automatic test_flush();
        do_reset();
        port_en = 2'b11; rd_en = 1'b0;
        src1.push_back(9'h055);
        refresh();
        for (int i = 0; i < 6; i++) step();
        total++; if (flush1_n != 1) $display("FAIL flush_pulses got %0d exp 1", flush1_n); else passed++;
        total++; if (src1.size() != 0) $display("FAIL flush_discard got %0d words exp 0", src1.size()); else passed++;
        total++; if (ev_port.size() != 0) $display("FAIL flush_nogrant got %0d grants exp 0", ev_port.size()); else passed++;
        total++; if (frame_cnt1 !== 16'd0) $display("FAIL flush_cnt1 got %0d exp 0", frame_cnt1); else passed++;
    endtask

    task automatic test_underrun();
        logic [8:0] exp_w [4];
        int n = 0;
        exp_w = '{9'h1FF, 9'h1AA, 9'h1BB, 9'h0CC};
        do_reset();
        port_en = 2'b11; rd_en = 1'b1;
        for (int i = 0; i < 4; i++) src0.push_back(exp_w[i]);
        refresh();
        while (rx.size() < 2 && n < 10) begin step(); n++; end
        hold0 = 1'b1; refresh();
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if (grant !== 2'b01) $display("FAIL ur_hold%0d got %b exp 01", i, grant); else passed++;
        end
        hold0 = 1'b0; refresh();
        n = 0;
        while (frame_cnt0 != 16'd1 && n < 20) begin step(); n++; end
        step();
        total++; if (ur_n != 1) $display("FAIL ur_pulses got %0d exp 1", ur_n); else passed++;
        total++; if (ev_port.size() != 1) $display("FAIL ur_grants got %0d exp 1", ev_port.size()); else passed++;
        total++; if (frame_cnt0 !== 16'd1) $display("FAIL ur_cnt0 got %0d exp 1", frame_cnt0); else passed++;
        total++; if (rx.size() != 4) $display("FAIL ur_rx_len got %0d exp 4", rx.size()); else passed++;
        for (int i = 0; i < 4 && i < rx.size(); i++) begin
            total++; if (rx[i] !== exp_w[i]) $display("FAIL ur_rx%0d got %h exp %h", i, rx[i], exp_w[i]); else passed++;
        end
    endtask

    task automatic test_reset_midframe();
        int n = 0;
        do_reset();
        port_en = 2'b11; rd_en = 1'b1;
        push_frame(1, 2); push_frame(1, 6);
        while (ev_port.size() < 2 && n < 60) begin step(); n++; end
        step();
        total++; if (grant !== 2'b10 || frame_cnt1 !== 16'd1) $display("FAIL rstmid_pre got grant=%b cnt1=%0d exp 10/1", grant, frame_cnt1); else passed++;
        rst_n = 1'b0;
        #1;
        total++; if (grant !== 2'b00) $display("FAIL rstmid_grant got %b exp 00", grant); else passed++;
        total++; if (empty !== 1'b1 || dout !== 9'h000) $display("FAIL rstmid_out got empty=%b dout=%h exp 1/000", empty, dout); else passed++;
        total++; if (rd_en1 !== 1'b0) $display("FAIL rstmid_rd_en1 got %b exp 0", rd_en1); else passed++;
        total++; if (frame_cnt0 !== 16'h0 || frame_cnt1 !== 16'h0) $display("FAIL rstmid_cnt got %0d/%0d exp 0/0", frame_cnt0, frame_cnt1); else passed++;
        model_reset();
        src1.delete();
        push_frame(0, 3); push_frame(1, 3);
        @(posedge clk); #2;
        rst_n = 1'b1;
        step();
        total++; if (grant !== 2'b01) $display("FAIL rstmid_first got %b exp 01", grant); else passed++;
    endtask

    task automatic test_port_en();
        int n = 0;
        do_reset();
        port_en = 2'b11; rd_en = 1'b1;
        push_frame(0, 5); push_frame(0, 4);
        step(); step();
        port_en = 2'b10;
        while (frame_cnt0 != 16'd1 && n < 20) begin step(); n++; end
        total++; if (frame_cnt0 !== 16'd1) $display("FAIL pen_complete got %0d exp 1", frame_cnt0); else passed++;
        for (int i = 0; i < 40; i++) step();
        total++; if (ev_port.size() != 1) $display("FAIL pen_blocked got %0d grants exp 1", ev_port.size()); else passed++;
        total++; if (src0.size() != 4) $display("FAIL pen_pending got %0d words exp 4", src0.size()); else passed++;
        port_en = 2'b11;
        n = 0;
        while (ev_port.size() < 2 && n < 5) begin step(); n++; end
        total++; if (ev_port.size() != 2) $display("FAIL pen_regrant got %0d grants exp 2", ev_port.size()); else passed++;
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (src0.size() < 4 && $urandom_range(3) == 0) push_frame(0, ($urandom_range(9) == 0) ? 1 : int'($urandom_range(7, 2)));
            if (src1.size() < 4 && $urandom_range(3) == 0) push_frame(1, ($urandom_range(9) == 0) ? 1 : int'($urandom_range(7, 2)));
            rd_en   = $urandom_range(3) != 0;
            port_en = ($urandom_range(7) == 0) ? 2'($urandom) : 2'b11;
            hold0   = $urandom_range(15) == 0;
            hold1   = $urandom_range(15) == 0;
            refresh();
            step();
        end
        total++; if (int'(frame_cnt0) + int'(frame_cnt1) < 20) $display("FAIL rand_progress got %0d frames exp >=20", int'(frame_cnt0) + int'(frame_cnt1)); else passed++;
    endtask

    initial begin
        rst_n = 1'b1; port_en = 2'b00; rd_en = 1'b0;
        refresh();
        test_reset();
        test_single_frame();
        test_contention();
        test_flush();
        test_underrun();
        test_reset_midframe();
        test_port_en();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
